// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and byte-enable helper
// for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        wen;
    logic [1:0]  size;
    logic        ext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [3:0] byte_mask(
    input logic [1:0] size,
    input logic [1:0] lane
  );
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << lane;
      SIZE_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: m = 4'b1111;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: load extraction/extension
// and store data replication with byte enables.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] rword_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        ext_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] wrep_o,
  output logic [3:0]  be_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    case (lane_i)
      2'd0:    rbyte = rword_i[7:0];
      2'd1:    rbyte = rword_i[15:8];
      2'd2:    rbyte = rword_i[23:16];
      default: rbyte = rword_i[31:24];
    endcase
    rhalf = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  always_comb begin
    case (size_i)
      SIZE_BYTE: rdata_o = {{24{ext_i & rbyte[7]}}, rbyte};
      SIZE_HALF: rdata_o = {{16{ext_i & rhalf[15]}}, rhalf};
      default:   rdata_o = rword_i;
    endcase
  end

  // Replicate so any enabled lane already sees the right byte
  always_comb begin
    case (size_i)
      SIZE_BYTE: wrep_o = {4{wdata_i[7:0]}};
      SIZE_HALF: wrep_o = {2{wdata_i[15:0]}};
      default:   wrep_o = wdata_i;
    endcase
    be_o = byte_mask(size_i, lane_i);
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one access at a time,
// commit on the edge entering RESP, registered response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wEn,
  input  logic [1:0]  req_size,
  input  logic        req_extend_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT =
    33'(4 * DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  req_t        req_in, cur;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        commit, err, wr_en;
  logic [AW-1:0] widx;
  logic [31:0] rword, ld_data, wrep;
  logic [3:0]  be;

  logic [31:0] mem_q [DEPTH_WORDS];

  assign req_in = '{
    wen:   req_wEn,
    size:  req_size,
    ext:   req_extend_sign,
    addr:  req_addr,
    wdata: req_wdata
  };

  // With LATENCY=1 the commit edge is the accept edge,
  // so the live request fields must be used there.
  assign cur  = (state_q == IDLE) ? req_in : req_q;
  assign widx = cur.addr[AW+1:2];
  assign rword = mem_q[widx];

  always_comb begin
    case (cur.size)
      SIZE_BYTE: err = 1'b0;
      SIZE_HALF: err = cur.addr[0];
      SIZE_WORD: err = |cur.addr[1:0];
      default:   err = 1'b1;
    endcase
    if ({1'b0, cur.addr} >= ADDR_LIMIT) err = 1'b1;
  end

  dmem_lane_align u_align (
    .rword_i (rword),
    .size_i  (cur.size),
    .lane_i  (cur.addr[1:0]),
    .ext_i   (cur.ext),
    .wdata_i (cur.wdata),
    .rdata_o (ld_data),
    .wrep_o  (wrep),
    .be_o    (be)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = req_in;
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      err_d   = err;
      rdata_d = (err | cur.wen) ? 32'd0 : ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Reset held across the commit edge cancels the store
  assign wr_en = commit & cur.wen & ~err & ~rst;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign stall      = req_valid & ~resp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// Vector, random-vs-model and corner-sequence bench for
// dmem_responder at LATENCY=2 and LATENCY=1.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_ready, req_wEn = 0;
  logic [1:0]  req_size = 0;
  logic        req_extend_sign = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;

  logic        b_valid = 0, b_ready, b_wEn = 0;
  logic [1:0]  b_size = 0;
  logic        b_ext = 0;
  logic [31:0] b_addr = 0, b_wdata = 0;
  logic        b_rvalid, b_err, b_stall;
  logic [31:0] b_rdata;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wEn(req_wEn), .req_size(req_size),
    .req_extend_sign(req_extend_sign),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready),
    .req_wEn(b_wEn), .req_size(b_size),
    .req_extend_sign(b_ext),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .resp_valid(b_rvalid), .resp_rdata(b_rdata),
    .resp_err(b_err), .stall(b_stall)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance.
  task automatic txn(input logic w, input logic [1:0] sz,
                     input logic ex, input logic [31:0] a,
                     input logic [31:0] wd,
                     output logic [31:0] rd, output logic er,
                     output int lat, output int stl,
                     output logic rdy_bad);
    @(negedge clk);
    rdy_bad = !req_ready;
    req_valid = 1; req_wEn = w; req_size = sz;
    req_extend_sign = ex; req_addr = a; req_wdata = wd;
    #1;
    stl = stall ? 1 : 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!resp_valid) begin
        if (stall) stl++;
        if (req_ready) rdy_bad = 1;
      end
    end while (!resp_valid && lat < 40);
    if (lat >= 40) chk("timeout", 64'(lat), 64'd2);
    rd = resp_rdata;
    er = resp_err;
    req_valid = 0;
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        ex;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eer;
  } vec_t;

  vec_t vt[14];

  logic [7:0] mdl [int];

  task automatic ref_op(input logic w, input logic [1:0] sz,
                        input logic ex, input logic [31:0] a,
                        input logic [31:0] wd,
                        output logic [31:0] rd, output logic e);
    int n;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
        (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'd4096);
    rd = 0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < n; i++) mdl[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++)
          v = v | (32'(mdl[int'(a) + i]) << (8*i));
        if (ex && n < 4 && v[8*n-1])
          v = v | ~((32'd1 << (8*n)) - 32'd1);
        rd = v;
      end
    end
  endtask

  logic [31:0] rd, erd;
  logic er, eer, rb;
  int lat, stl;
  logic [7:0] pat;

  initial begin
    vt[0]  = '{1, SIZE_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0};
    vt[1]  = '{0, SIZE_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0};
    vt[2]  = '{0, SIZE_BYTE, 1, 32'h13, 32'h0, 32'hFFFFFFDE, 0};
    vt[3]  = '{0, SIZE_BYTE, 0, 32'h13, 32'h0, 32'h000000DE, 0};
    vt[4]  = '{0, SIZE_HALF, 1, 32'h10, 32'h0, 32'hFFFFBEEF, 0};
    vt[5]  = '{0, SIZE_HALF, 0, 32'h12, 32'h0, 32'h0000DEAD, 0};
    vt[6]  = '{1, SIZE_BYTE, 0, 32'h11, 32'hAAAAAA55, 32'h0, 0};
    vt[7]  = '{0, SIZE_WORD, 1, 32'h10, 32'h0, 32'hDEAD55EF, 0};
    vt[8]  = '{0, SIZE_HALF, 1, 32'h11, 32'h0, 32'h0, 1};
    vt[9]  = '{1, SIZE_WORD, 0, 32'h12, 32'hFFFFFFFF, 32'h0, 1};
    vt[10] = '{1, 2'b11, 0, 32'h10, 32'h01234567, 32'h0, 1};
    vt[11] = '{1, SIZE_WORD, 0, 32'h1000, 32'h11111111, 32'h0, 1};
    vt[12] = '{0, SIZE_WORD, 0, 32'h1000, 32'h0, 32'h0, 1};
    vt[13] = '{0, SIZE_WORD, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0};

    @(negedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_ready_l1", 64'(b_ready), 64'd1);
    rst = 0;

    for (int i = 0; i < 14; i++) begin
      txn(vt[i].w, vt[i].sz, vt[i].ex, vt[i].a, vt[i].wd,
          rd, er, lat, stl, rb);
      chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vt[i].erd));
      chk($sformatf("vec%0d_err", i), 64'(er), 64'(vt[i].eer));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_stall", i), 64'(stl), 64'd2);
      chk($sformatf("vec%0d_ready", i), 64'(rb), 64'd0);
    end

    for (int i = 0; i < 16; i++) begin
      erd = $urandom;
      ref_op(1, SIZE_WORD, 0, 32'h100 + 32'(4*i), erd, rd, er);
      txn(1, SIZE_WORD, 0, 32'h100 + 32'(4*i), erd,
          rd, er, lat, stl, rb);
    end
    for (int i = 0; i < 80; i++) begin
      logic w, ex;
      logic [1:0] sz;
      logic [31:0] a, wd;
      w  = 1'($urandom_range(0, 1));
      ex = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      if ($urandom_range(0, 7) == 0)
        a = 32'h1000 + 32'($urandom_range(0, 15));
      else
        a = 32'h100 + 32'($urandom_range(0, 63));
      ref_op(w, sz, ex, a, wd, erd, eer);
      txn(w, sz, ex, a, wd, rd, er, lat, stl, rb);
      chk($sformatf("rand%0d_resp", i),
          {31'd0, er, rd}, {31'd0, eer, erd});
      chk($sformatf("rand%0d_latency", i), 64'(lat), 64'd2);
    end

    txn(1, SIZE_WORD, 0, 32'h20, 32'hCAFEF00D,
        rd, er, lat, stl, rb);
    txn(0, SIZE_WORD, 0, 32'h20, 32'h0, rd, er, lat, stl, rb);
    chk("pre_reset_load", 64'(rd), 64'hCAFEF00D);
    @(negedge clk);
    req_valid = 1; req_wEn = 1; req_size = SIZE_WORD;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(negedge clk);
    chk("busy_ready", 64'(req_ready), 64'd0);
    rst = 1;
    #1;
    chk("mid_rst_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_rdata", 64'(resp_rdata), 64'd0);
    chk("mid_rst_err", 64'(resp_err), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 0;
    rst = 0;
    @(negedge clk);
    chk("post_rst_valid", 64'(resp_valid), 64'd0);
    txn(0, SIZE_WORD, 0, 32'h20, 32'h0, rd, er, lat, stl, rb);
    chk("cancelled_store", 64'(rd), 64'hCAFEF00D);

    @(negedge clk);
    b_valid = 1; b_wEn = 1; b_size = SIZE_WORD;
    b_ext = 0; b_addr = 32'h40; b_wdata = 32'h0BADF00D;
    pat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat = {pat[6:0], b_rvalid};
    end
    chk("lat1_pattern", 64'(pat), 64'hAA);
    chk("lat1_ready", 64'(b_ready), 64'd1);
    b_wEn = 0;
    #1;
    chk("lat1_stall", 64'(b_stall), 64'd1);
    @(negedge clk);
    chk("lat1_load_valid", 64'(b_rvalid), 64'd1);
    chk("lat1_load_rdata", 64'(b_rdata), 64'h0BADF00D);
    chk("lat1_load_err", 64'(b_err), 64'd0);
    chk("lat1_resp_stall", 64'(b_stall), 64'd0);
    b_valid = 0;
    @(negedge clk);
    chk("lat1_idle", {62'd0, b_rvalid, b_ready}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
